// File: rtl/baluga_isa_pkg.sv
// Shared ISA constants, opcodes and fetch-stage state encoding.
// Imported by the fetch stage and its program counter.
package baluga_isa_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;
  localparam int OP_W    = 4;

  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  localparam logic [OP_W-1:0] OP_LOAD     = 4'b0001;
  localparam logic [OP_W-1:0] OP_SET_TO   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SET_FROM = 4'b0110;
  localparam logic [OP_W-1:0] OP_INCR     = 4'b0111;
  localparam logic [OP_W-1:0] OP_SET_LOW  = 4'b1010;
  localparam logic [OP_W-1:0] OP_HALT     = 4'b1111;
  localparam logic [OP_W-1:0] HALT_OP     = OP_HALT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  function automatic logic [OP_W-1:0] opcode_of(
    input logic [INSTR_W-1:0] instr
  );
    return instr[INSTR_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter: load has priority over increment, else hold.
// Ports: clock, reset_n, i_load, i_load_pc, i_inc -> o_pc.
module program_counter
  import baluga_isa_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      // natural wrap: 8'hFF + 1 -> 8'h00
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, ROM addressing, instruction register, stall/redirect/HALT.
// Ports: clock, reset_n, enable, stall, redirect(+pc), rom i/f, instr outputs.
module instruction_fetch
  import baluga_isa_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted
);

  fetch_state_t r_state;
  fetch_state_t w_state_d;

  logic [ADDR_W-1:0]  w_pc;
  logic               w_pc_load;
  logic               w_pc_inc;
  logic               w_ir_load;
  logic               w_valid_d;
  logic               w_halted_d;
  logic               w_is_halt;

  logic [INSTR_W-1:0] r_instr_out;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_valid;
  logic               r_halted;

  program_counter u_pc (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (w_pc_load),
    .i_load_pc (redirect_pc),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  assign w_is_halt = (opcode_of(rom_instruction) == HALT_OP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_pc_load  = 1'b0;
    w_pc_inc   = 1'b0;
    w_ir_load  = 1'b0;
    w_valid_d  = r_valid;
    w_halted_d = r_halted;
    unique case (r_state)
      ST_IDLE: begin
        if (enable) w_state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          // flush wins over stall and over a HALT being fetched
          w_pc_load = 1'b1;
          w_valid_d = 1'b0;
        end else if (!stall) begin
          w_ir_load = 1'b1;
          w_valid_d = 1'b1;
          if (w_is_halt) begin
            w_state_d  = ST_HALT;
            w_halted_d = 1'b1;
          end else begin
            w_pc_inc = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (redirect) begin
          w_pc_load  = 1'b1;
          w_valid_d  = 1'b0;
          w_halted_d = 1'b0;
          w_state_d  = ST_RUN;
        end else if (!stall) begin
          // HALT instruction consumed by decoder
          w_valid_d = 1'b0;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_out <= '0;
      r_instr_pc  <= '0;
      r_valid     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (w_ir_load) begin
        r_instr_out <= rom_instruction;
        r_instr_pc  <= w_pc;
      end
      r_valid  <= w_valid_d;
      r_halted <= w_halted_d;
    end
  end

  assign rom_address = w_pc;
  assign instr_out   = r_instr_out;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a combinational ROM model.
// Addr-tagged ROM words {1'b0, addr}; a HALT word is patched in as needed.
module tb_instruction_fetch;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] rom_address;
  logic [8:0] rom_instruction;
  logic [8:0] instr_out;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       halted;

  logic [8:0] rom [256];

  int errors;
  int checks;

  instruction_fetch dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .halted          (halted)
  );

  assign rom_instruction = rom[rom_address];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_out(input string tag,
                         input logic [7:0] e_addr,
                         input logic [7:0] e_ipc,
                         input logic       e_vld,
                         input logic       e_hlt);
    chk({tag, ".addr"}, 32'(rom_address), 32'(e_addr));
    chk({tag, ".ipc"},  32'(instr_pc),    32'(e_ipc));
    chk({tag, ".vld"},  32'(instr_valid), 32'(e_vld));
    chk({tag, ".hlt"},  32'(halted),      32'(e_hlt));
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset_n     = 1'b0;
    enable      = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    for (int a = 0; a < 256; a++) rom[a] = {1'b0, 8'(a)};

    // reset state
    step();
    step();
    reset_n = 1'b1;
    chk("rst.iout", 32'(instr_out), 32'h0);
    chk_out("rst", 8'h00, 8'h00, 1'b0, 1'b0);

    // IDLE ignores redirect, issues nothing
    redirect    = 1'b1;
    redirect_pc = 8'h33;
    step();
    chk_out("idle", 8'h00, 8'h00, 1'b0, 1'b0);
    redirect = 1'b0;

    // enable: no fetch in the IDLE cycle
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk_out("en", 8'h00, 8'h00, 1'b0, 1'b0);

    // 1: streaming 0..3
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("run%0d", i), 8'(i + 1), 8'(i), 1'b1, 1'b0);
      chk($sformatf("run%0d.iout", i), 32'(instr_out), 32'(i));
    end

    // 2: stall at pc=5
    step();
    chk_out("pre_stall", 8'h05, 8'h04, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("stall%0d", i), 8'h05, 8'h04, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    chk_out("unstall", 8'h06, 8'h05, 1'b1, 1'b0);
    step();
    chk_out("unstall2", 8'h07, 8'h06, 1'b1, 1'b0);

    // 3: redirect beats stall
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    stall       = 1'b1;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk_out("redir", 8'h40, 8'h06, 1'b0, 1'b0);
    step();
    chk_out("redir2", 8'h41, 8'h40, 1'b1, 1'b0);

    // 4: wrap at 8'hFF
    redirect    = 1'b1;
    redirect_pc = 8'hFF;
    step();
    redirect = 1'b0;
    chk_out("wrap0", 8'hFF, 8'h40, 1'b0, 1'b0);
    step();
    chk_out("wrap1", 8'h00, 8'hFF, 1'b1, 1'b0);
    chk("wrap1.iout", 32'(instr_out), 32'h0FF);
    step();
    chk_out("wrap2", 8'h01, 8'h00, 1'b1, 1'b0);

    // 5: HALT word at addr 3
    rom[3] = 9'b1111_00000;
    step();
    chk_out("h_a", 8'h02, 8'h01, 1'b1, 1'b0);
    step();
    chk_out("h_b", 8'h03, 8'h02, 1'b1, 1'b0);
    step();
    chk_out("h_issue", 8'h03, 8'h03, 1'b1, 1'b1);
    chk("h_issue.iout", 32'(instr_out), 32'h1E0);
    step();
    chk_out("h_cons", 8'h03, 8'h03, 1'b0, 1'b1);
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk_out("h_stay", 8'h03, 8'h03, 1'b0, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 8'h00;
    step();
    redirect = 1'b0;
    chk_out("h_redir", 8'h00, 8'h03, 1'b0, 1'b0);
    step();
    chk_out("h_resume", 8'h01, 8'h00, 1'b1, 1'b0);

    // 6: async reset between edges
    #2 reset_n = 1'b0;
    #1;
    chk("ar.iout", 32'(instr_out), 32'h0);
    chk_out("ar", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk_out("ar_idle", 8'h00, 8'h00, 1'b0, 1'b0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk_out("ar_en", 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    chk_out("ar_f0", 8'h01, 8'h00, 1'b1, 1'b0);

    // redirect while HALT is being fetched: no halt
    step();
    chk_out("rh_a", 8'h02, 8'h01, 1'b1, 1'b0);
    step();
    chk_out("rh_b", 8'h03, 8'h02, 1'b1, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    step();
    redirect = 1'b0;
    chk_out("rh_c", 8'h10, 8'h02, 1'b0, 1'b0);
    step();
    chk_out("rh_d", 8'h11, 8'h10, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
